id_ex_hazard_ctrl: RTL and testbench

//  Hazard/stall controller for the ID->EX boundary of the 5-stage MIPS pipeline.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/hazard_cmp.sv | 17 +
 rtl/id_ex_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, M-field layout
// and the hard-wired zero register.
package pipe_pkg;

    // Hazard controller states; RUN must stay 0 so reset lands in normal flow.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    // The ID/EX M field is {MemRead, MemWrite}; MemRead sits in bit 1.
    localparam int M_FIELD_W    = 2;
    localparam int MEM_READ_BIT = 1;

    // Register $zero never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags when the load in EX writes a register that the
// instruction in ID is about to read. Purely combinational.
import pipe_pkg::*;

module hazard_cmp (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    // A load into $zero is harmless, so it never stalls.
    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID->EX hazard/stall controller: load-use stalls, MULT/DIV freeze, branch
// flush and a saturating stall-cycle counter. Outputs are Mealy so a stall
// takes effect in the same cycle the hazard is visible.
import pipe_pkg::*;

module id_ex_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int FLUSH_DEPTH   = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic             ex_muldiv_start,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MAX_P = (MULDIV_CYCLES > FLUSH_DEPTH) ? MULDIV_CYCLES : FLUSH_DEPTH;
    localparam int CW    = $clog2(MAX_P) + 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          load_use;

    hazard_cmp u_cmp (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .load_use    (load_use)
    );

    assign busy = (state != RUN);

    // Output decode from state and live inputs; reset forces the free-run pattern.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (ex_muldiv_start) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_hold  = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                MD_BUSY: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_hold  = 1'b1;
                end
                FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end
            endcase
        end
    end

    // State and down-counter; MD_BUSY and FLUSH ignore all hazard inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        if (FLUSH_DEPTH > 1) begin
                            state <= FLUSH;
                            cnt   <= CW'(FLUSH_DEPTH - 1);
                        end
                    end else if (ex_muldiv_start) begin
                        state <= MD_BUSY;
                        cnt   <= CW'(MULDIV_CYCLES - 2);
                    end
                end
                MD_BUSY: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FLUSH: begin
                    if (cnt == CW'(1)) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Count every cycle the PC is frozen, sticking at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed self-checking bench for id_ex_hazard_ctrl with MULDIV_CYCLES=4,
// FLUSH_DEPTH=2, CNT_W=4. Inputs change on the falling edge, outputs are
// sampled 1ns later, well away from the rising edge.
module tb_id_ex_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_rt;
    logic       ex_mem_read;
    logic       ex_muldiv_start;
    logic       ex_branch_taken;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       id_ex_hold;
    logic       busy;
    logic [3:0] stall_count;

    int checks;
    int failures;

    id_ex_hazard_ctrl #(
        .MULDIV_CYCLES (4),
        .FLUSH_DEPTH   (2),
        .CNT_W         (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_rt           (ex_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_muldiv_start (ex_muldiv_start),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .id_ex_hold      (id_ex_hold),
        .busy            (busy),
        .stall_count     (stall_count)
    );

    // 10ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Wait for the falling edge, drive one input vector, then settle.
    task automatic applyStimulus(input logic mr, input logic [4:0] ert,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic md, input logic br);
        @(negedge clk);
        ex_mem_read     = mr;
        ex_rt           = ert;
        id_rs           = rs;
        id_rt           = rt;
        ex_muldiv_start = md;
        ex_branch_taken = br;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_pc_write"}, 32'(pc_write), 32'd1);
        checkOutput({tag, "_if_id_write"}, 32'(if_id_write), 32'd1);
        checkOutput({tag, "_flush"}, 32'(if_id_flush), 32'd0);
        checkOutput({tag, "_bubble"}, 32'(id_ex_bubble), 32'd0);
        checkOutput({tag, "_hold"}, 32'(id_ex_hold), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b0;
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        ex_rt           = 5'd0;
        ex_mem_read     = 1'b0;
        ex_muldiv_start = 1'b0;
        ex_branch_taken = 1'b0;

        // Reset with hazard-looking inputs: outputs must stay free-running.
        $display("[TB] reset");
        applyStimulus(1'b1, 5'd9, 5'd9, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        checkIdle("rst");
        checkOutput("rst_stall_count", 32'(stall_count), 32'd0);
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        checkOutput("rst_loaduse_pc_write", 32'(pc_write), 32'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;

        // Load-use via rs, then via rt, then non-hazards.
        $display("[TB] load-use");
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_rs_bubble", 32'(id_ex_bubble), 32'd1);
        checkOutput("lu_rs_pc_write", 32'(pc_write), 32'd0);
        checkOutput("lu_rs_if_id_write", 32'(if_id_write), 32'd0);
        checkOutput("lu_rs_hold", 32'(id_ex_hold), 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        checkIdle("lu_after");
        checkOutput("lu_count1", 32'(stall_count), 32'd1);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_zero_pc_write", 32'(pc_write), 32'd1);
        checkOutput("lu_zero_bubble", 32'(id_ex_bubble), 32'd0);
        applyStimulus(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
        checkOutput("lu_rt_pc_write", 32'(pc_write), 32'd0);
        checkOutput("lu_rt_bubble", 32'(id_ex_bubble), 32'd1);
        applyStimulus(1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0);
        checkOutput("lu_nomatch_pc_write", 32'(pc_write), 32'd1);
        applyStimulus(1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0);
        checkOutput("lu_noread_pc_write", 32'(pc_write), 32'd1);
        checkOutput("lu_count2", 32'(stall_count), 32'd2);

        // MULT/DIV: four held cycles, branch and load-use mid-way ignored.
        $display("[TB] muldiv");
        resetDut();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("md_c1_hold", 32'(id_ex_hold), 32'd1);
        checkOutput("md_c1_pc_write", 32'(pc_write), 32'd0);
        checkOutput("md_c1_bubble", 32'(id_ex_bubble), 32'd0);
        checkOutput("md_c1_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("md_c2_hold", 32'(id_ex_hold), 32'd1);
        checkOutput("md_c2_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1);
        checkOutput("md_c3_hold", 32'(id_ex_hold), 32'd1);
        checkOutput("md_c3_flush", 32'(if_id_flush), 32'd0);
        checkOutput("md_c3_bubble", 32'(id_ex_bubble), 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("md_c4_hold", 32'(id_ex_hold), 32'd1);
        checkOutput("md_c4_if_id_write", 32'(if_id_write), 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkIdle("md_done");
        checkOutput("md_count4", 32'(stall_count), 32'd4);

        // Branch with simultaneous load-use: two flush cycles, no stall.
        $display("[TB] branch");
        resetDut();
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
        checkOutput("br_c1_flush", 32'(if_id_flush), 32'd1);
        checkOutput("br_c1_bubble", 32'(id_ex_bubble), 32'd1);
        checkOutput("br_c1_pc_write", 32'(pc_write), 32'd1);
        checkOutput("br_c1_hold", 32'(id_ex_hold), 32'd0);
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        checkOutput("br_c2_flush", 32'(if_id_flush), 32'd1);
        checkOutput("br_c2_bubble", 32'(id_ex_bubble), 32'd1);
        checkOutput("br_c2_pc_write", 32'(pc_write), 32'd1);
        checkOutput("br_c2_hold", 32'(id_ex_hold), 32'd0);
        checkOutput("br_c2_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkIdle("br_done");
        checkOutput("br_count0", 32'(stall_count), 32'd0);

        // Reset during MD_BUSY aborts straight to RUN.
        $display("[TB] reset mid-muldiv");
        resetDut();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("rmd_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        checkIdle("rmd_in_reset");
        checkOutput("rmd_count0", 32'(stall_count), 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkIdle("rmd_after");
        checkOutput("rmd_count_after", 32'(stall_count), 32'd0);

        // Twenty back-to-back load-use stalls saturate the 4-bit counter.
        $display("[TB] saturation");
        resetDut();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 5'd12, 5'd12, 5'd1, 1'b0, 1'b0);
            if (i == 14) begin
                checkOutput("sat_count14", 32'(stall_count), 32'd14);
            end
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("sat_count15", 32'(stall_count), 32'd15);
        checkOutput("sat_pc_write", 32'(pc_write), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
